// File: rtl/req_queue4_if.sv
// rtl/req_queue4_if.sv - push, grant and pop-output bundle between lane clients, selector and req_queue4.
interface req_queue4_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic [3:0]          req;
  logic [3:0]          gnt;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic [4*CW-1:0]     lane_cnt;

  modport master (
    output in_valid, in_data, gnt,
    input  in_ready, req, out_valid, out_data, out_id, lane_cnt
  );

  modport slave (
    input  in_valid, in_data, gnt,
    output in_ready, req, out_valid, out_data, out_id, lane_cnt
  );
endinterface

// File: rtl/req_queue4.sv
// rtl/req_queue4.sv - four per-lane request FIFOs feeding a rotating selector, one registered pop port.
// Define REQ_QUEUE_ERR_EN to add the sticky err output for illegal grants.
module req_queue4 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  req_queue4_if.slave q
`ifdef REQ_QUEUE_ERR_EN
  ,
  output logic        err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem  [4][DEPTH];
  logic [AW-1:0]     wptr [4];
  logic [AW-1:0]     rptr [4];
  logic [CW-1:0]     cnt  [4];

  logic [3:0]        ready_v;
  logic [3:0]        req_v;
  logic [4*CW-1:0]   cnt_v;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic              pop_any;
  logic [1:0]        pop_lane;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [1:0]        out_id_r;

  // Flags come from the registered counts only, so a full lane stays not-ready even while popped.
  always_comb begin
    ready_v = '0;
    req_v   = '0;
    cnt_v   = '0;
    push    = '0;
    for (int i = 0; i < 4; i++) begin
      ready_v[i]          = (cnt[i] != CW'(DEPTH));
      req_v[i]            = (cnt[i] != '0);
      cnt_v[i*CW +: CW]   = cnt[i];
      push[i]             = q.in_valid[i] && ready_v[i];
    end
  end

  // Downward scan leaves the lowest-index live grant selected when gnt is multi-hot.
  always_comb begin
    pop      = '0;
    pop_any  = 1'b0;
    pop_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (q.gnt[i] && req_v[i]) begin
        pop_any  = 1'b1;
        pop_lane = 2'(i);
      end
    end
    if (pop_any) begin
      pop[pop_lane] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= q.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          wptr[i] <= wptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + 1'b1;
        end
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      out_valid_r <= pop_any;
      if (pop_any) begin
        out_data_r <= mem[pop_lane][rptr[pop_lane]];
        out_id_r   <= pop_lane;
      end
    end
  end

`ifdef REQ_QUEUE_ERR_EN
  logic illegal;

  assign illegal = ((q.gnt & (q.gnt - 4'd1)) != 4'd0) || ((q.gnt & ~req_v) != 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`endif

  assign q.in_ready  = ready_v;
  assign q.req       = req_v;
  assign q.lane_cnt  = cnt_v;
  assign q.out_valid = out_valid_r;
  assign q.out_data  = out_data_r;
  assign q.out_id    = out_id_r;
endmodule

// File: tb/tb_req_queue4.sv
// tb/tb_req_queue4.sv - randomized and directed bench for req_queue4 against a queue-based model.
module tb_req_queue4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clock;
  logic reset;
`ifdef REQ_QUEUE_ERR_EN
  logic err;
`endif

  req_queue4_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  req_queue4 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
`ifdef REQ_QUEUE_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per lane plus the last popped entry.
  logic [DATA_W-1:0] mq [4][$];
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic [1:0]        exp_id;
  logic              exp_err;
  int                sz [4];
  bit                popped;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_id    = 2'd0;
      exp_err   = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
      if ($countones(bus.gnt) > 1) exp_err = 1'b1;
      for (int i = 0; i < 4; i++) if (bus.gnt[i] && sz[i] == 0) exp_err = 1'b1;
      popped = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!popped && bus.gnt[i] && sz[i] != 0) begin
          popped   = 1'b1;
          exp_data = mq[i].pop_front();
          exp_id   = 2'(i);
        end
      end
      exp_valid = popped;
      for (int i = 0; i < 4; i++) begin
        if (bus.in_valid[i] && sz[i] != DEPTH) mq[i].push_back(bus.in_data[i*DATA_W +: DATA_W]);
      end
    end
  end

  logic [3:0]      m_req, m_rdy;
  logic [4*CW-1:0] m_cnt;

  always @(negedge clock) begin
    if (!reset) begin
      m_req = '0;
      m_rdy = '0;
      m_cnt = '0;
      for (int i = 0; i < 4; i++) begin
        m_req[i] = mq[i].size() != 0;
        m_rdy[i] = mq[i].size() != DEPTH;
        m_cnt[i*CW +: CW] = CW'(mq[i].size());
      end
      chk("req", 32'(bus.req), 32'(m_req));
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk("lane_cnt", 32'(bus.lane_cnt), 32'(m_cnt));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("out_data", 32'(bus.out_data), 32'(exp_data));
      chk("out_id", 32'(bus.out_id), 32'(exp_id));
`ifdef REQ_QUEUE_ERR_EN
      chk("err", 32'(err), 32'(exp_err));
`endif
    end
  end

  function automatic logic [CW-1:0] lcnt(input int i);
    return bus.lane_cnt[i*CW +: CW];
  endfunction

  // Inputs change 1 time unit after the edge; return after the edge that consumed them.
  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.gnt      = g;
    @(posedge clock);
    #1;
  endtask

  int         rr_ptr;
  logic [3:0] g_sel;
  int         rsel;

  initial begin
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.gnt      = '0;
    reset = 1'b1;
    #6;
    reset = 1'b0;

    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'hf);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_lane_cnt", 32'(bus.lane_cnt), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_id", 32'(bus.out_id), 32'h0);
`ifdef REQ_QUEUE_ERR_EN
    chk("rst_err", 32'(err), 32'h0);
`endif
    @(posedge clock);
    #1;

    // Single push/pop on lane 2
    drive(4'b0100, 32'h00A5_0000, 4'b0000);
    chk("single_req", 32'(bus.req), 32'h4);
    chk("single_cnt2", 32'(lcnt(2)), 32'd1);
    drive(4'b0000, 32'h0, 4'b0100);
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data", 32'(bus.out_data), 32'hA5);
    chk("single_id", 32'(bus.out_id), 32'd2);
    chk("single_req_after", 32'(bus.req), 32'h0);
    drive(4'b0000, 32'h0, 4'b0000);
    chk("idle_valid", 32'(bus.out_valid), 32'h0);
    chk("idle_hold_data", 32'(bus.out_data), 32'hA5);

    // Fill lane 0, overflow, drain through pointer wrap
    for (int k = 1; k <= 4; k++) drive(4'b0001, 32'(k), 4'b0000);
    chk("full_in_ready", 32'(bus.in_ready), 32'he);
    chk("full_cnt0", 32'(lcnt(0)), 32'd4);
    drive(4'b0001, 32'h99, 4'b0000);
    chk("overflow_cnt0", 32'(lcnt(0)), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      drive(4'b0000, 32'h0, 4'b0001);
      chk("fifo_order", 32'(bus.out_data), 32'(k));
    end
    drive(4'b0001, 32'h05, 4'b0000);
    drive(4'b0000, 32'h0, 4'b0001);
    chk("wrap_data", 32'(bus.out_data), 32'h05);

    // Rotating drain: lane i holds {i0, i1}
    drive(4'hf, 32'h3020_1000, 4'b0000);
    drive(4'hf, 32'h3121_1101, 4'b0000);
    rr_ptr = 0;
    for (int k = 0; k < 8; k++) begin
      g_sel = '0;
      for (int j = 0; j < 4; j++) begin
        if (g_sel == '0 && bus.req[(rr_ptr + j) % 4]) begin
          g_sel[(rr_ptr + j) % 4] = 1'b1;
          rr_ptr = (rr_ptr + j + 1) % 4;
        end
      end
      drive(4'b0000, 32'h0, g_sel);
      chk("rr_id", 32'(bus.out_id), 32'(k % 4));
      chk("rr_data", 32'(bus.out_data), 32'(((k % 4) << 4) | (k / 4)));
    end
    chk("rr_req_end", 32'(bus.req), 32'h0);

    // Simultaneous push and pop on lane 1, then full lane with pop
    for (int k = 1; k <= 3; k++) drive(4'b0010, 32'(8'h40 + k) << 8, 4'b0000);
    chk("sim_cnt1_pre", 32'(lcnt(1)), 32'd3);
    drive(4'b0010, 32'h0000_4400, 4'b0010);
    chk("sim_cnt1", 32'(lcnt(1)), 32'd3);
    chk("sim_data", 32'(bus.out_data), 32'h41);
    drive(4'b0010, 32'h0000_4500, 4'b0000);
    chk("sim_full", 32'(bus.in_ready[1]), 32'h0);
    drive(4'b0010, 32'h0000_4600, 4'b0010);
    chk("full_pop_cnt1", 32'(lcnt(1)), 32'(DEPTH - 1));
    chk("full_pop_data", 32'(bus.out_data), 32'h42);

    // Illegal grants
    drive(4'b0100, 32'h0051_0000, 4'b0000);
    drive(4'b0000, 32'h0, 4'b0110);
    chk("multi_id", 32'(bus.out_id), 32'd1);
    chk("multi_data", 32'(bus.out_data), 32'h43);
    chk("multi_cnt2", 32'(lcnt(2)), 32'd1);
`ifdef REQ_QUEUE_ERR_EN
    chk("multi_err", 32'(err), 32'h1);
`endif
    drive(4'b0000, 32'h0, 4'b1000);
    chk("empty_gnt_valid", 32'(bus.out_valid), 32'h0);
    drive(4'b0000, 32'h0, 4'b0000);
    drive(4'b0000, 32'h0, 4'b0000);
`ifdef REQ_QUEUE_ERR_EN
    chk("err_sticky", 32'(err), 32'h1);
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 6)      g_sel = 4'(1 << $urandom_range(0, 3));
      else if (rsel < 8) g_sel = 4'b0000;
      else               g_sel = 4'($urandom);
      drive(4'($urandom), $urandom, g_sel);
    end

    // Asynchronous reset mid-operation
    drive(4'hf, $urandom, 4'b0000);
    #3;
    reset = 1'b1;
    #1;
    chk("async_req", 32'(bus.req), 32'h0);
    chk("async_in_ready", 32'(bus.in_ready), 32'hf);
    chk("async_valid", 32'(bus.out_valid), 32'h0);
    chk("async_cnt", 32'(bus.lane_cnt), 32'h0);
    chk("async_data", 32'(bus.out_data), 32'h0);
`ifdef REQ_QUEUE_ERR_EN
    chk("async_err", 32'(err), 32'h0);
`endif
    #2;
    reset = 1'b0;
    bus.in_valid = '0;
    bus.gnt      = '0;
    @(posedge clock);
    #1;
    drive(4'b0001, 32'h77, 4'b0000);
    drive(4'b0000, 32'h0, 4'b0001);
    chk("post_reset_data", 32'(bus.out_data), 32'h77);

    for (int c = 0; c < 300; c++) begin
      g_sel = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      drive(4'($urandom), $urandom, g_sel);
    end
    drive(4'b0000, 32'h0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/req_queue4.md
Name: req_queue4

Overview:
- Upstream feeder for the 4-way rotating priority selector.
- Holds up to DEPTH pending requests per requester (lanes 0..3) in independent FIFOs.
- Drives req[i] high whenever lane i is non-empty, and consumes the selector's one-hot gnt to pop that lane's head.
- Each popped entry goes to a single registered output tagged with its lane id.

Parameters:
- DATA_W, 8, payload width per request entry.
- DEPTH, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-lane push request from clients.
- in_data  input  4*DATA_W  per-lane payload; lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  4  per-lane FIFO not full.
- req  output  4  per-lane non-empty; connects to the selector's req.
- gnt  input  4  one-hot grant from the selector.
- out_valid  output  1  registered: an entry was popped last cycle.
- out_data  output  DATA_W  registered payload of the popped entry.
- out_id  output  2  registered lane index of the popped entry.
- lane_cnt  output  4*(log2(DEPTH)+1)  per-lane occupancy; lane i at [i*(log2(DEPTH)+1) +: log2(DEPTH)+1].

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - all read/write pointers and occupancy counts go to 0;
  - req=0000, in_ready=1111, out_valid=0, out_data=0, out_id=0.
  - Stored contents are discarded, not drained.
- Per-lane storage:
  - Circular buffer with log2(DEPTH)-bit read and write pointers; pointers wrap DEPTH-1 -> 0.
  - Occupancy count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Flags:
  - in_ready[i] = (cnt[i] != DEPTH).
  - req[i] = (cnt[i] != 0).
  - Both are derived from registered state only, with no combinational path from in_valid or gnt.
- Push:
  - Occurs when in_valid[i] && in_ready[i]; writes in_data lane i at wptr[i], then wptr[i]++.
  - in_data is don't-care when in_valid=0.
- Pop:
  - Occurs when gnt[i] && req[i]; rptr[i]++.
  - On the next edge: out_valid=1, out_data=mem[i][rptr], out_id=i.
  - Latency from grant cycle to output is 1 cycle.
- No pop in a cycle: out_valid=0 next cycle. out_data and out_id hold their previous values.
- Simultaneous push and pop on the same lane: both occur and the count is unchanged.
- Full lane: in_ready=0 even if the same lane is popped that cycle. There is no write-through when full.
- Empty lane:
  - A push makes req[i] rise on the following cycle. There is no same-cycle bypass.
  - A grant to an empty lane (gnt[i] && !req[i]) is ignored: no pointer change, no out_valid.
- Multi-hot gnt (illegal):
  - Only the lowest-index bit i with gnt[i] && req[i] is popped; other lanes are untouched.
  - Flagged when the error feature is compiled in.
- out_valid carries no backpressure. The consumer must accept one entry per cycle.
- Lanes are independent. Pushes to all four lanes plus a pop from one lane may all occur in the same cycle.

Optional Feature:
- Macro REQ_QUEUE_ERR_EN.
- Defined: adds output port err (1 bit) and error logic.
  - err is sticky, reset to 0.
  - err is set on the edge after any cycle where gnt is not one-hot-or-zero, or where gnt[i] && !req[i].
  - err stays set until reset.
- Undefined: the err port and its logic are absent. Illegal grants are still handled as described in Behaviour.

Test Plan:
- Reset then idle:
  - reset=1 for 6 time units, then 0 -> req=0000, in_ready=1111, out_valid=0, lane_cnt all 0.
- Single push/pop:
  - Push 8'hA5 on lane 2 -> req=0100 on the next cycle.
  - gnt=0100 -> on the next edge out_valid=1, out_data=A5, out_id=2; then req=0000.
- Fill and full:
  - Push 4 entries (01..04) into lane 0 with gnt=0 -> in_ready=1110, lane0 cnt=4.
  - A 5th push is dropped.
  - Four grants to lane 0 return 01,02,03,04 in order; pointers wrap correctly.
  - Push 05 then grant -> out_data=05.
- Rotating drain with the selector connected:
  - Lanes 0..3 each hold 2 entries (lane i: {i0,i1}) with en=1.
  - Output sequence: out_id 0,1,2,3,0,1,2,3, with data 00,10,20,30,01,11,21,31.
  - req ends at 0000.
- Simultaneous events:
  - Lane 1 holds 3 entries; push and gnt=0010 in the same cycle -> cnt stays 3, head pops.
  - Lane 1 full: gnt=0010 with in_valid[1]=1 -> no push, cnt=DEPTH-1.
- Illegal grant:
  - gnt=0110 with lanes 1 and 2 non-empty -> only lane 1 pops (out_id=1).
  - gnt=1000 with lane 3 empty -> no output.
  - With REQ_QUEUE_ERR_EN defined -> err=1 and stays 1 until reset.
